// File: rtl/bcharger_timed_if.sv
// Comparator flags in, charger mode controls out, for bcharger_timed.
// BCHARGER_THERM_EN adds the debounced over-temperature flag thot.
interface bcharger_timed_if;
  logic       en;
  logic       vtrkl;
  logic       vterm;
  logic       iterm;
  logic       vrchrg;
`ifdef BCHARGER_THERM_EN
  logic       thot;
`endif
  logic       trkl;
  logic       fast;
  logic       vconst;
  logic       done;
  logic       fault;
  logic [2:0] state_o;
  logic [1:0] fault_code;

`ifdef BCHARGER_THERM_EN
  modport master (
    output en, vtrkl, vterm, iterm, vrchrg, thot,
    input  trkl, fast, vconst, done, fault, state_o, fault_code
  );
  modport slave (
    input  en, vtrkl, vterm, iterm, vrchrg, thot,
    output trkl, fast, vconst, done, fault, state_o, fault_code
  );
`else
  modport master (
    output en, vtrkl, vterm, iterm, vrchrg,
    input  trkl, fast, vconst, done, fault, state_o, fault_code
  );
  modport slave (
    input  en, vtrkl, vterm, iterm, vrchrg,
    output trkl, fast, vconst, done, fault, state_o, fault_code
  );
`endif
endinterface

// File: rtl/bcharger_timed.sv
// Li-ion charge controller: debounced comparator flags, per-phase timeouts, sticky FAULT.
// Optional thermal suspend enabled by defining BCHARGER_THERM_EN.
module bcharger_timed #(
  parameter int DEB_CYC   = 4,
  parameter int TMR_W     = 16,
  parameter int TRKL_TO   = 1000,
  parameter int FAST_TO   = 20000,
  parameter int VCONST_TO = 20000
) (
  input  logic            clk,
  input  logic            reset,
  bcharger_timed_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TRKL   = 3'd1,
    ST_FAST   = 3'd2,
    ST_VCONST = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

`ifdef BCHARGER_THERM_EN
  localparam int NF     = 5;
  localparam int F_THOT = 4;
`else
  localparam int NF     = 4;
`endif
  localparam int F_VTRKL  = 0;
  localparam int F_VTERM  = 1;
  localparam int F_ITERM  = 2;
  localparam int F_VRCHRG = 3;

  localparam int              CW          = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0]   CNT_LAST    = CW'(DEB_CYC - 1);
  localparam logic [TMR_W-1:0] TRKL_TO_L   = TMR_W'(TRKL_TO);
  localparam logic [TMR_W-1:0] FAST_TO_L   = TMR_W'(FAST_TO);
  localparam logic [TMR_W-1:0] VCONST_TO_L = TMR_W'(VCONST_TO);
  localparam logic [TMR_W-1:0] TMR_MAX     = {TMR_W{1'b1}};
  localparam logic [TMR_W-1:0] TMR_ZERO    = {TMR_W{1'b0}};

  logic [NF-1:0]    raw_s;
  logic [NF-1:0]    deb_r;
  logic [NF-1:0]    deb_nxt_s;
  logic [CW-1:0]    cnt_r     [NF];
  logic [CW-1:0]    cnt_nxt_s [NF];

  state_t           state_r;
  state_t           state_nxt_s;
  state_t           adv_s;
  logic [TMR_W-1:0] timer_r;
  logic [TMR_W-1:0] timer_nxt_s;
  logic [TMR_W-1:0] to_s;
  logic [1:0]       code_r;
  logic [1:0]       code_nxt_s;
  logic [1:0]       phase_code_s;
  logic             in_phase_s;
  logic             exit_s;
  logic             timeout_s;
  logic             hold_s;
  logic             hold_nxt_s;

  logic             trkl_r;
  logic             fast_r;
  logic             vconst_r;
  logic             done_r;
  logic             fault_r;

`ifdef BCHARGER_THERM_EN
  assign raw_s      = {bus.thot, bus.vrchrg, bus.iterm, bus.vterm, bus.vtrkl};
  assign hold_s     = deb_r[F_THOT];
  assign hold_nxt_s = deb_nxt_s[F_THOT];
`else
  assign raw_s      = {bus.vrchrg, bus.iterm, bus.vterm, bus.vtrkl};
  assign hold_s     = 1'b0;
  assign hold_nxt_s = 1'b0;
`endif

  // Per-flag debounce: a flag flips only after DEB_CYC consecutive disagreeing samples.
  always_comb begin
    deb_nxt_s = deb_r;
    for (int i = 0; i < NF; i++) begin
      cnt_nxt_s[i] = {CW{1'b0}};
      if (raw_s[i] != deb_r[i]) begin
        if (cnt_r[i] == CNT_LAST) begin
          deb_nxt_s[i] = raw_s[i];
        end else begin
          cnt_nxt_s[i] = cnt_r[i] + 1'b1;
        end
      end else begin
        cnt_nxt_s[i] = {CW{1'b0}};
      end
    end
  end

  // Next state, fault code and phase timer; an exit condition outranks a same-edge timeout.
  always_comb begin
    in_phase_s   = 1'b0;
    exit_s       = 1'b0;
    to_s         = TMR_ZERO;
    adv_s        = ST_IDLE;
    phase_code_s = 2'd0;
    case (state_r)
      ST_TRKL: begin
        in_phase_s   = 1'b1;
        exit_s       = deb_r[F_VTRKL];
        to_s         = TRKL_TO_L;
        adv_s        = ST_FAST;
        phase_code_s = 2'd1;
      end
      ST_FAST: begin
        in_phase_s   = 1'b1;
        exit_s       = deb_r[F_VTERM];
        to_s         = FAST_TO_L;
        adv_s        = ST_VCONST;
        phase_code_s = 2'd2;
      end
      ST_VCONST: begin
        in_phase_s   = 1'b1;
        exit_s       = deb_r[F_ITERM];
        to_s         = VCONST_TO_L;
        adv_s        = ST_DONE;
        phase_code_s = 2'd3;
      end
      default: begin
        in_phase_s = 1'b0;
      end
    endcase

    timeout_s   = (to_s != TMR_ZERO) && (timer_r == (to_s - 1'b1));
    state_nxt_s = state_r;
    if (!bus.en) begin
      state_nxt_s = ST_IDLE;
    end else if (in_phase_s) begin
      if (hold_s) begin
        state_nxt_s = state_r;
      end else if (exit_s) begin
        state_nxt_s = adv_s;
      end else if (timeout_s) begin
        state_nxt_s = ST_FAULT;
      end else begin
        state_nxt_s = state_r;
      end
    end else begin
      case (state_r)
        ST_IDLE:  state_nxt_s = ST_TRKL;
        ST_DONE:  state_nxt_s = deb_r[F_VRCHRG] ? ST_TRKL : ST_DONE;
        ST_FAULT: state_nxt_s = ST_FAULT;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end

    if (state_nxt_s == ST_IDLE) begin
      code_nxt_s = 2'd0;
    end else if ((state_nxt_s == ST_FAULT) && in_phase_s) begin
      code_nxt_s = phase_code_s;
    end else begin
      code_nxt_s = code_r;
    end

    if ((state_nxt_s != state_r) || !in_phase_s) begin
      timer_nxt_s = TMR_ZERO;
    end else if (hold_s || (timer_r == TMR_MAX)) begin
      timer_nxt_s = timer_r;
    end else begin
      timer_nxt_s = timer_r + 1'b1;
    end
  end

  // State, debounce, timer and mode-output registers; outputs decode the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      timer_r  <= TMR_ZERO;
      code_r   <= 2'd0;
      deb_r    <= {NF{1'b0}};
      trkl_r   <= 1'b0;
      fast_r   <= 1'b0;
      vconst_r <= 1'b0;
      done_r   <= 1'b0;
      fault_r  <= 1'b0;
      for (int i = 0; i < NF; i++) begin
        cnt_r[i] <= {CW{1'b0}};
      end
    end else begin
      state_r  <= state_nxt_s;
      timer_r  <= timer_nxt_s;
      code_r   <= code_nxt_s;
      deb_r    <= deb_nxt_s;
      trkl_r   <= (state_nxt_s == ST_TRKL) && !hold_nxt_s;
      fast_r   <= (state_nxt_s == ST_FAST) && !hold_nxt_s;
      vconst_r <= (state_nxt_s == ST_VCONST) && !hold_nxt_s;
      done_r   <= (state_nxt_s == ST_DONE);
      fault_r  <= (state_nxt_s == ST_FAULT);
      for (int i = 0; i < NF; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  assign bus.trkl       = trkl_r;
  assign bus.fast       = fast_r;
  assign bus.vconst     = vconst_r;
  assign bus.done       = done_r;
  assign bus.fault      = fault_r;
  assign bus.state_o    = state_r;
  assign bus.fault_code = code_r;

endmodule

// File: tb/tb_bcharger_timed.sv
// Directed + randomized bench for bcharger_timed against a cycle-count reference model.
module tb_bcharger_timed;
  localparam int DEB = 4;
  localparam int TTO = 100;
  localparam int FTO = 200;
  localparam int VTO = 0;

  localparam int S_IDLE   = 0;
  localparam int S_TRKL   = 1;
  localparam int S_FAST   = 2;
  localparam int S_VCONST = 3;
  localparam int S_DONE   = 4;
  localparam int S_FAULT  = 5;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // reference model: state, fault code, edge counter, phase entry edge, debounced flags
  int       m_state = 0;
  int       m_code  = 0;
  int       n       = 0;
  int       entry_n = 0;
  bit [3:0] m_deb   = 4'b0000;
  int       last_same [4];

  always #5 clk = ~clk;

  bcharger_timed_if bus ();

  bcharger_timed #(
    .DEB_CYC  (DEB),
    .TMR_W    (16),
    .TRKL_TO  (TTO),
    .FAST_TO  (FTO),
    .VCONST_TO(VTO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic int phase_to(int s);
    case (s)
      S_TRKL:   return TTO;
      S_FAST:   return FTO;
      S_VCONST: return VTO;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [9:0] mk_exp(int s, int c);
    logic [2:0] st;
    logic [1:0] cd;
    st = s[2:0];
    cd = c[1:0];
    return {st, cd, s == S_TRKL, s == S_FAST, s == S_VCONST, s == S_DONE, s == S_FAULT};
  endfunction

  function automatic logic [9:0] obs_vec();
    return {bus.state_o, bus.fault_code, bus.trkl, bus.fast, bus.vconst, bus.done, bus.fault};
  endfunction

  // one clock edge of the model; raw = {vrchrg, iterm, vterm, vtrkl}
  task automatic model_edge(bit rst_v, bit en_v, bit [3:0] raw);
    int ns;
    n++;
    if (!rst_v) begin
      m_state = S_IDLE;
      m_code  = 0;
      m_deb   = 4'b0000;
      entry_n = n;
      for (int f = 0; f < 4; f++) last_same[f] = n;
    end else begin
      ns = m_state;
      if (!en_v) ns = S_IDLE;
      else if (m_state == S_IDLE) ns = S_TRKL;
      else if (m_state >= S_TRKL && m_state <= S_VCONST) begin
        if (m_deb[m_state-1]) ns = m_state + 1;
        else if (phase_to(m_state) != 0 && (n - entry_n) == phase_to(m_state)) begin
          ns     = S_FAULT;
          m_code = m_state;
        end
      end else if (m_state == S_DONE && m_deb[3]) ns = S_TRKL;
      if (ns == S_IDLE) m_code = 0;
      if (ns != m_state) entry_n = n;
      m_state = ns;
      for (int f = 0; f < 4; f++) begin
        if (raw[f] == m_deb[f]) last_same[f] = n;
        else if ((n - last_same[f]) >= DEB) begin
          m_deb[f]     = raw[f];
          last_same[f] = n;
        end
      end
    end
  endtask

  task automatic check(string tag, logic [9:0] obs, logic [9:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
    end
  endtask

  task automatic set_raw(bit [3:0] r);
    bus.vtrkl  = r[0];
    bus.vterm  = r[1];
    bus.iterm  = r[2];
    bus.vrchrg = r[3];
  endtask

  task automatic tick(string tag);
    bit       rv;
    bit       ev;
    bit [3:0] rw;
    rv = reset;
    ev = bus.en;
    rw = {bus.vrchrg, bus.iterm, bus.vterm, bus.vtrkl};
    @(posedge clk);
    model_edge(rv, ev, rw);
    #1;
    check(tag, obs_vec(), mk_exp(m_state, m_code));
  endtask

  initial begin
    bit [3:0] rr;
    bus.en = 1'b1;
    set_raw(4'b0000);
    reset = 1'b0;
    tick("rst");
    tick("rst");
    check("rst_idle", obs_vec(), mk_exp(S_IDLE, 0));
    reset = 1'b1;
    tick("release");
    check("trkl_entry", obs_vec(), mk_exp(S_TRKL, 0));

    set_raw(4'b0001); repeat (3) tick("glitch_hi");
    set_raw(4'b0000); repeat (3) tick("glitch_lo");
    check("glitch_stay", obs_vec(), mk_exp(S_TRKL, 0));
    set_raw(4'b0001); repeat (4) tick("deb_vtrkl");
    check("deb_flip_edge", obs_vec(), mk_exp(S_TRKL, 0));
    tick("fast_entry");
    check("fast_entry", obs_vec(), mk_exp(S_FAST, 0));

    repeat (199) tick("fast_wait");
    check("fast_before_to", obs_vec(), mk_exp(S_FAST, 0));
    tick("fast_to");
    check("fast_timeout", obs_vec(), mk_exp(S_FAULT, 2));
    repeat (5) tick("fault_hold");
    check("fault_sticky", obs_vec(), mk_exp(S_FAULT, 2));
    bus.en = 1'b0; tick("en_off");
    check("fault_clear", obs_vec(), mk_exp(S_IDLE, 0));

    bus.en = 1'b1;
    tick("idle_trkl");
    tick("trkl_fast");
    check("refast", obs_vec(), mk_exp(S_FAST, 0));
    repeat (195) tick("fast_wait2");
    set_raw(4'b0011); repeat (4) tick("deb_vterm");
    check("fast_before_to2", obs_vec(), mk_exp(S_FAST, 0));
    tick("exit_vs_to");
    check("exit_beats_timeout", obs_vec(), mk_exp(S_VCONST, 0));
    repeat (10000) tick("vconst_hold");
    check("vconst_no_timeout", obs_vec(), mk_exp(S_VCONST, 0));

    set_raw(4'b0111); repeat (5) tick("deb_iterm");
    check("done", obs_vec(), mk_exp(S_DONE, 0));
    set_raw(4'b1000); repeat (5) tick("deb_vrchrg");
    check("recharge", obs_vec(), mk_exp(S_TRKL, 0));
    repeat (99) tick("trkl_wait");
    check("trkl_before_to", obs_vec(), mk_exp(S_TRKL, 0));
    tick("trkl_to");
    check("trkl_timeout", obs_vec(), mk_exp(S_FAULT, 1));
    bus.en = 1'b0; tick("en_off2");
    check("fault_clear2", obs_vec(), mk_exp(S_IDLE, 0));

    for (int i = 0; i < 4000; i++) begin
      bus.en = ($urandom_range(0, 199) != 0);
      reset  = ($urandom_range(0, 999) != 0);
      rr = {bus.vrchrg, bus.iterm, bus.vterm, bus.vtrkl};
      for (int f = 0; f < 4; f++) begin
        if ($urandom_range(0, 5) == 0) rr[f] = ~rr[f];
      end
      set_raw(rr);
      tick("random");
    end

    reset = 1'b1;
    bus.en = 1'b0;
    set_raw(4'b0000);
    repeat (5) tick("settle");
    bus.en = 1'b1;
    set_raw(4'b0011);
    for (int i = 0; i < 40 && bus.state_o != 3'd3; i++) tick("to_vconst");
    check("reach_vconst", obs_vec(), mk_exp(S_VCONST, 0));
    reset = 1'b0; tick("rst_mid");
    check("rst_in_vconst", obs_vec(), mk_exp(S_IDLE, 0));
    reset = 1'b1; tick("post_rst");
    check("post_rst_trkl", obs_vec(), mk_exp(S_TRKL, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
